// File: rtl/shift_pipe_pkg.sv
// Shared op encodings and the level-to-stage grouping used by shift_pipe and its bench.
package shift_pkg;

   localparam int OP_W = 3;
   typedef logic [OP_W-1:0] op_t;

   localparam op_t OP_SLL = 3'b000;
   localparam op_t OP_SRL = 3'b001;
   localparam op_t OP_SRA = 3'b011;
   localparam op_t OP_ROL = 3'b100;
   localparam op_t OP_ROR = 3'b101;

   function automatic logic op_is_legal(op_t op);
      logic legal;
      case (op)
         OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR: legal = 1'b1;
         default:                                legal = 1'b0;
      endcase
      return legal;
   endfunction

   // Each stage takes ceil(remaining levels / remaining stages), so earlier stages are never lighter.
   function automatic int stage_levels(int levels, int stages, int stage);
      int rem;
      int n;
      rem = levels;
      n   = 0;
      for (int s = 0; s <= stage; s++) begin
         n   = (rem + stages - s - 1) / (stages - s);
         rem = rem - n;
      end
      return n;
   endfunction

   function automatic int stage_first(int levels, int stages, int stage);
      int f;
      f = 0;
      for (int s = 0; s < stage; s++) f = f + stage_levels(levels, stages, s);
      return f;
   endfunction

   function automatic int level_stage(int levels, int stages, int level);
      int st;
      st = stages - 1;
      for (int s = stages - 1; s >= 0; s--) begin
         if (level < stage_first(levels, stages, s) + stage_levels(levels, stages, s)) st = s;
      end
      return st;
   endfunction

endpackage

// File: rtl/shift_pipe_if.sv
// Valid/ready bus between the shifter and its producer/consumer.
interface shift_pipe_if
   import shift_pkg::*;
#(
   parameter int WIDTH = 32
);
   logic                     in_valid;
   logic                     in_ready;
   op_t                      in_op;
   logic [$clog2(WIDTH)-1:0] in_amt;
   logic [WIDTH-1:0]         in_data;
   logic                     out_valid;
   logic                     out_ready;
   logic [WIDTH-1:0]         out_data;
   logic                     out_err;

   modport slave (
      input  in_valid, in_op, in_amt, in_data, out_ready,
      output in_ready, out_valid, out_data, out_err
   );

   modport master (
      output in_valid, in_op, in_amt, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_err
   );
endinterface

// File: rtl/shift_pipe_level.sv
// One combinational mux level of the barrel shifter: applies a fixed distance DIST when sel is set.
module shift_level
   import shift_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DIST  = 1
) (
   input  logic [WIDTH-1:0] data,
   input  op_t              op,
   input  logic             sel,
   output logic [WIDTH-1:0] result
);
   logic signed [WIDTH-1:0] sdata;

   assign sdata = $signed(data);

   always_comb begin
      result = data;
      if (sel) begin
         case (op)
            OP_SLL:  result = data << DIST;
            OP_SRL:  result = data >> DIST;
            OP_SRA:  result = sdata >>> DIST;
            OP_ROL:  result = (data << DIST) | (data >> (WIDTH - DIST));
            OP_ROR:  result = (data >> DIST) | (data << (WIDTH - DIST));
            default: result = data;
         endcase
      end
   end
endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter/rotator with a global stall driven by the output slot.
module shift_pipe
   import shift_pkg::*;
#(
   parameter int          WIDTH     = 32,
   parameter int          LATENCY   = 2,
   parameter logic [63:0] ERR_VALUE = 64'd1
) (
   input  logic        clk,
   input  logic        reset,
   shift_pipe_if.slave bus,
   output logic        busy
);
   localparam int             LEVELS   = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] ERR_DATA = ERR_VALUE[WIDTH-1:0];

   logic                advance;
   logic [LATENCY-1:0]  vld_p;
   logic [LATENCY-1:0]  err_p;
   logic [WIDTH-1:0]    data_p [LATENCY];
   op_t                 op_p   [LATENCY];
   logic [LEVELS-1:0]   amt_p  [LATENCY];

   logic [LATENCY-1:0]  st_vld;
   logic [LATENCY-1:0]  st_err;
   logic [WIDTH-1:0]    st_data [LATENCY];
   op_t                 st_op   [LATENCY];
   logic [LEVELS-1:0]   st_amt  [LATENCY];
   logic [WIDTH-1:0]    st_out  [LATENCY];

   logic [WIDTH-1:0]    lvl_in  [LEVELS];
   logic [WIDTH-1:0]    lvl_out [LEVELS];

   assign advance      = !vld_p[LATENCY-1] || bus.out_ready;
   assign bus.in_ready = advance;

   // Stage s consumes what stage s-1 registered; stage 0 consumes the input port.
   always_comb begin
      st_vld  = '0;
      st_err  = '0;
      st_data = '{default: '0};
      st_op   = '{default: '0};
      st_amt  = '{default: '0};
      st_vld[0]  = bus.in_valid;
      st_err[0]  = bus.in_valid && !op_is_legal(bus.in_op);
      st_data[0] = bus.in_data;
      st_op[0]   = bus.in_op;
      st_amt[0]  = bus.in_amt;
      for (int s = 1; s < LATENCY; s++) begin
         st_vld[s]  = vld_p[s-1];
         st_err[s]  = err_p[s-1];
         st_data[s] = data_p[s-1];
         st_op[s]   = op_p[s-1];
         st_amt[s]  = amt_p[s-1];
      end
   end

   // Level j applies distance WIDTH>>(j+1), steered by amount bit LEVELS-1-j.
   for (genvar j = 0; j < LEVELS; j++) begin : g_level
      localparam int ST    = level_stage(LEVELS, LATENCY, j);
      localparam int FIRST = stage_first(LEVELS, LATENCY, ST);

      if (j == FIRST) begin : g_head
         assign lvl_in[j] = st_data[ST];
      end else begin : g_chain
         assign lvl_in[j] = lvl_out[j-1];
      end

      shift_level #(
         .WIDTH (WIDTH),
         .DIST  (WIDTH >> (j + 1))
      ) u_level (
         .data   (lvl_in[j]),
         .op     (st_op[ST]),
         .sel    (st_amt[ST][LEVELS-1-j]),
         .result (lvl_out[j])
      );
   end

   for (genvar s = 0; s < LATENCY; s++) begin : g_stage_out
      assign st_out[s] = lvl_out[stage_first(LEVELS, LATENCY, s) + stage_levels(LEVELS, LATENCY, s) - 1];
   end

   // Stage registers; the last one is the output slot, which is why its data is also cleared.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p              <= '0;
         err_p              <= '0;
         data_p[LATENCY-1]  <= '0;
      end else if (advance) begin
         vld_p <= st_vld;
         err_p <= st_err;
         for (int s = 0; s < LATENCY - 1; s++) data_p[s] <= st_out[s];
         data_p[LATENCY-1] <= st_err[LATENCY-1] ? ERR_DATA : st_out[LATENCY-1];
         for (int s = 0; s < LATENCY; s++) begin
            op_p[s]  <= st_op[s];
            amt_p[s] <= st_amt[s];
         end
      end
   end

   assign bus.out_valid = vld_p[LATENCY-1];
   assign bus.out_data  = data_p[LATENCY-1];
   assign bus.out_err   = err_p[LATENCY-1];
   assign busy          = |vld_p;
endmodule

// File: tb/tb_shift_pipe.sv
// Directed + randomized bench for shift_pipe against a bit-at-a-time reference model.
module tb_shift_pipe;
   localparam int W     = 32;
   localparam int LAT_A = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        out_ready;
   logic [2:0]  in_op;
   logic [4:0]  in_amt;
   logic [31:0] in_data;
   logic        busy_a, busy_b, busy_c;

   shift_pipe_if #(.WIDTH(W)) ifa ();
   shift_pipe_if #(.WIDTH(W)) ifb ();
   shift_pipe_if #(.WIDTH(W)) ifc ();

   assign ifa.in_valid = in_valid;  assign ifb.in_valid = in_valid;  assign ifc.in_valid = in_valid;
   assign ifa.in_op    = in_op;     assign ifb.in_op    = in_op;     assign ifc.in_op    = in_op;
   assign ifa.in_amt   = in_amt;    assign ifb.in_amt   = in_amt;    assign ifc.in_amt   = in_amt;
   assign ifa.in_data  = in_data;   assign ifb.in_data  = in_data;   assign ifc.in_data  = in_data;
   assign ifa.out_ready = out_ready; assign ifb.out_ready = out_ready; assign ifc.out_ready = out_ready;

   shift_pipe #(.WIDTH(W), .LATENCY(2)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave), .busy(busy_a));
   shift_pipe #(.WIDTH(W), .LATENCY(1)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave), .busy(busy_b));
   shift_pipe #(.WIDTH(W), .LATENCY(5)) dut_c (.clk(clk), .reset(reset), .bus(ifc.slave), .busy(busy_c));

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] d;
      logic        e;
      int          acc;
   } exp_t;

   exp_t        sb[$];
   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          stall_left = 0;
   int          popped = 0;
   bit          check_lat = 0;
   bit          rand_ready = 0;
   bit          last_acc = 0;
   bit          holding = 0;
   logic [31:0] hold_d;
   logic [31:0] exp_d;
   logic        exp_e;

   // Reference: apply the op one bit position at a time, amt times.
   function automatic logic [32:0] model(logic [2:0] op, logic [4:0] amt, logic [31:0] d);
      logic [31:0] r;
      r = d;
      if (op == 3'b010 || op == 3'b110 || op == 3'b111) return {1'b1, 32'd1};
      for (int i = 0; i < int'(amt); i++) begin
         case (op)
            3'b000:  r = {r[30:0], 1'b0};
            3'b001:  r = {1'b0, r[31:1]};
            3'b011:  r = {r[31], r[31:1]};
            3'b100:  r = {r[30:0], r[31]};
            default: r = {r[0], r[31:1]};
         endcase
      end
      return {1'b0, r};
   endfunction

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cycle();
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : (stall_left == 0);
      @(negedge clk);
      last_acc = 0;
      if (!reset && in_valid && ifa.in_ready) begin
         sb.push_back('{exp_d, exp_e, cyc});
         last_acc = 1;
      end
      if (!reset && ifa.out_valid) begin
         if (!ifa.out_ready) begin
            chk("stall_in_ready", ifa.in_ready, 0);
            if (holding) chk("stall_hold", ifa.out_data, hold_d);
            hold_d  = ifa.out_data;
            holding = 1;
         end else begin
            holding = 0;
            if (sb.size() == 0) chk("spurious_out", ifa.out_valid, 0);
            else begin
               exp_t e;
               e = sb.pop_front();
               chk("out_data", ifa.out_data, e.d);
               chk("out_err", ifa.out_err, e.e);
               if (check_lat) chk("latency", cyc - e.acc, LAT_A);
               popped++;
            end
         end
      end else holding = 0;
      if (stall_left > 0) stall_left--;
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(logic [2:0] op, logic [4:0] amt, logic [31:0] d, logic [31:0] ed, logic ee);
      in_valid = 1; in_op = op; in_amt = amt; in_data = d;
      exp_d = ed; exp_e = ee;
      for (int k = 0; k < 64; k++) begin
         cycle();
         if (last_acc) break;
      end
      if (!last_acc) chk("accept_timeout", last_acc, 1);
      in_valid = 0; in_op = 'x; in_amt = 'x; in_data = 'x;
   endtask

   task automatic drain();
      for (int k = 0; k < 100; k++) begin
         if (sb.size() == 0 && !busy_a) break;
         cycle();
      end
      chk("drain_empty", sb.size(), 0);
      chk("drain_busy", busy_a, 0);
   endtask

   task automatic chk_reset_state(string tag, logic ov, logic bz, logic [31:0] od, logic oe, logic ir);
      chk({tag, "_out_valid"}, ov, 0);
      chk({tag, "_busy"}, bz, 0);
      chk({tag, "_out_data"}, od, 0);
      chk({tag, "_out_err"}, oe, 0);
      chk({tag, "_in_ready"}, ir, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  r_op;
      logic [4:0]  r_amt;
      logic [31:0] r_d;
      logic [32:0] m;
      logic [2:0]  legal_ops [5];
      legal_ops = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b101};

      reset = 1; in_valid = 0; out_ready = 1;
      in_op = 'x; in_amt = 'x; in_data = 'x;
      repeat (2) cycle();
      reset = 0;
      chk_reset_state("reset_a", ifa.out_valid, busy_a, ifa.out_data, ifa.out_err, ifa.in_ready);

      check_lat = 1;
      issue(3'b000, 5'd31, 32'h0000_0001, 32'h8000_0000, 0);
      drain();

      issue(3'b011, 5'd4, 32'h8000_0000, 32'hF800_0000, 0);
      issue(3'b001, 5'd4, 32'h8000_0000, 32'h0800_0000, 0);
      drain();

      issue(3'b101, 5'd4, 32'h0000_00F1, 32'h1000_000F, 0);
      issue(3'b100, 5'd4, 32'h0000_00F1, 32'h0000_0F10, 0);
      foreach (legal_ops[i]) issue(legal_ops[i], 5'd0, 32'h0000_00F1, 32'h0000_00F1, 0);
      drain();

      issue(3'b010, 5'd7, 32'hDEAD_BEEF, 32'h0000_0001, 1);
      issue(3'b000, 5'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
      drain();

      check_lat = 0;
      popped = 0;
      issue(3'b000, 5'd1, 32'd1, 32'd2, 0);
      stall_left = 4;
      issue(3'b000, 5'd1, 32'd2, 32'd4, 0);
      issue(3'b000, 5'd1, 32'd3, 32'd6, 0);
      issue(3'b000, 5'd1, 32'd4, 32'd8, 0);
      drain();
      chk("stall_count", popped, 4);

      rand_ready = 1;
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 4) == 0) cycle();
         else begin
            r_op  = 3'($urandom_range(0, 7));
            r_amt = 5'($urandom);
            r_d   = $urandom;
            m     = model(r_op, r_amt, r_d);
            issue(r_op, r_amt, r_d, m[31:0], m[32]);
         end
      end
      rand_ready = 0;
      drain();

      issue(3'b000, 5'd3, 32'h1, 32'h8, 0);
      issue(3'b100, 5'd1, 32'h8000_0000, 32'h1, 0);
      reset = 1;
      cycle();
      reset = 0;
      sb.delete();
      chk_reset_state("midreset_a", ifa.out_valid, busy_a, ifa.out_data, ifa.out_err, ifa.in_ready);
      chk_reset_state("midreset_b", ifb.out_valid, busy_b, ifb.out_data, ifb.out_err, ifb.in_ready);
      chk_reset_state("midreset_c", ifc.out_valid, busy_c, ifc.out_data, ifc.out_err, ifc.in_ready);
      for (int k = 0; k < 8; k++) begin
         cycle();
         chk("quiet_a", ifa.out_valid, 0);
         chk("quiet_b", ifb.out_valid, 0);
         chk("quiet_c", ifc.out_valid, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
